rs_18_16_encoder: RTL and testbench

Streaming systematic Reed-Solomon RS(18,16) encoder over GF(2^8). Takes 16 data symbols per block on a valid/ready input and emits 18 symbols per block on a valid/ready output: the 16 data symbols unchanged, then 2 parity symbols. It sits on the transmit side of the RS(18,16) link and is the counterpart of the syndrome/decoder path. Every block it emits yields zero syndromes at roots α and α².

---
 rtl/rs_18_16_encoder_pkg.sv | 35 +++
 rtl/rs_18_16_encoder_if.sv | 25 ++
 rtl/rs_18_16_lfsr.sv | 28 ++
 rtl/rs_18_16_encoder.sv | 115 +++++++++++
 tb/tb_rs_18_16_encoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rs_18_16_encoder_pkg.sv
// Shared RS(18,16) definitions over GF(2^8): field constants, generator taps,
// encoder state encoding and constant-coefficient field multiply.
package rs_18_16_pkg;

  localparam int SYMBOL_WIDTH = 8;
  localparam int K            = 16;
  localparam int N            = 18;

  localparam logic [8:0] FIELD_POLY = 9'h11D;
  localparam logic [7:0] G1         = 8'h06;
  localparam logic [7:0] G0         = 8'h08;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    PAR_HI = 2'd1,
    PAR_LO = 2'd2
  } state_t;

  // With a constant multiplier the loop folds to a fixed XOR network.
  function automatic logic [SYMBOL_WIDTH-1:0] gf_mul_const(
    input logic [SYMBOL_WIDTH-1:0] symbol,
    input logic [SYMBOL_WIDTH-1:0] constant
  );
    logic [SYMBOL_WIDTH-1:0] acc;
    logic [SYMBOL_WIDTH-1:0] pwr;
    acc = '0;
    pwr = symbol;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (constant[i]) acc = acc ^ pwr;
      pwr = {pwr[SYMBOL_WIDTH-2:0], 1'b0} ^ (pwr[SYMBOL_WIDTH-1] ? FIELD_POLY[SYMBOL_WIDTH-1:0] : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_18_16_encoder_if.sv
// Symbol stream bundle around the encoder: upstream valid/ready input and
// downstream valid/ready output with parity/last markers.
interface rs_18_16_encoder_if;
  import rs_18_16_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [SYMBOL_WIDTH-1:0] in_symbol;
  logic                    out_valid;
  logic                    out_ready;
  logic [SYMBOL_WIDTH-1:0] out_symbol;
  logic                    out_parity;
  logic                    out_last;

  modport slave (
    input  in_valid, in_symbol, out_ready,
    output in_ready, out_valid, out_symbol, out_parity, out_last
  );

  modport master (
    output in_valid, in_symbol, out_ready,
    input  in_ready, out_valid, out_symbol, out_parity, out_last
  );

endinterface

// File: rtl/rs_18_16_lfsr.sv
// Two-register parity LFSR dividing the message by g(x) = x^2 + G1*x + G0.
module rs_18_16_lfsr
  import rs_18_16_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic                    clear,
  input  logic [SYMBOL_WIDTH-1:0] d,
  output logic [SYMBOL_WIDTH-1:0] r1,
  output logic [SYMBOL_WIDTH-1:0] r0
);

  logic [SYMBOL_WIDTH-1:0] fb;

  assign fb = d ^ r1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r1 <= '0;
      r0 <= '0;
    end else if (shift) begin
      r1 <= r0 ^ gf_mul_const(fb, G1);
      r0 <= gf_mul_const(fb, G0);
    end
  end

endmodule

// File: rtl/rs_18_16_encoder.sv
// Streaming systematic RS(18,16) encoder: 16 data symbols pass through,
// followed by the two LFSR parity symbols, behind a single output register.
module rs_18_16_encoder
  import rs_18_16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  rs_18_16_encoder_if.slave  bus
);

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    slot_free;
  logic                    load;
  logic                    shift;
  logic                    clear;
  logic [SYMBOL_WIDTH-1:0] r1, r0;
  logic [SYMBOL_WIDTH-1:0] sym_nxt;
  logic                    par_nxt, last_nxt;
  logic                    vld_p1;
  logic [SYMBOL_WIDTH-1:0] sym_p1;
  logic                    par_p1, last_p1;

  assign slot_free = !vld_p1 || bus.out_ready;

  rs_18_16_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .clear (clear),
    .d     (bus.in_symbol),
    .r1    (r1),
    .r0    (r0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DATA;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    load         = 1'b0;
    shift        = 1'b0;
    clear        = 1'b0;
    sym_nxt      = sym_p1;
    par_nxt      = par_p1;
    last_nxt     = last_p1;
    bus.in_ready = 1'b0;
    unique case (state)
      DATA: begin
        bus.in_ready = slot_free;
        if (bus.in_valid && slot_free) begin
          load     = 1'b1;
          shift    = 1'b1;
          sym_nxt  = bus.in_symbol;
          par_nxt  = 1'b0;
          last_nxt = 1'b0;
          cnt_nxt  = cnt + 4'd1;
          if (cnt == 4'(K - 1)) state_nxt = PAR_HI;
        end
      end
      PAR_HI: begin
        if (slot_free) begin
          load      = 1'b1;
          sym_nxt   = r1;
          par_nxt   = 1'b1;
          last_nxt  = 1'b0;
          state_nxt = PAR_LO;
        end
      end
      PAR_LO: begin
        // Clearing here lets the next block's first symbol shift into a clean LFSR.
        if (slot_free) begin
          load      = 1'b1;
          clear     = 1'b1;
          sym_nxt   = r0;
          par_nxt   = 1'b1;
          last_nxt  = 1'b1;
          state_nxt = DATA;
        end
      end
      default: state_nxt = DATA;
    endcase
  end

  // Output stage p1
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sym_p1  <= '0;
      par_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      sym_p1  <= sym_nxt;
      par_p1  <= par_nxt;
      last_p1 <= last_nxt;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_symbol = sym_p1;
  assign bus.out_parity = par_p1;
  assign bus.out_last   = last_p1;

endmodule

// File: tb/tb_rs_18_16_encoder.sv
// Directed and randomized bench for rs_18_16_encoder against a long-division
// RS(18,16) reference model with table-based GF(2^8) arithmetic.
module tb_rs_18_16_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rs_18_16_encoder_if bus();

  rs_18_16_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_t[255];
  int         log_t[256];

  logic [9:0] exp_q[$];
  logic [7:0] blk[$];
  logic [7:0] rx[$];
  logic       stall_prev = 1'b0;
  logic [9:0] stall_val  = '0;
  logic [7:0] seen_p1 = '0;
  logic [7:0] seen_p0 = '0;
  int         npop = 0;
  int         nblk = 0;

  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [7:0] eval_at(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    foreach (rx[i]) s = fmul(s, x) ^ rx[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected codeword = data followed by the remainder of x^2*m(x) divided by g(x).
  task automatic push_model(input logic [7:0] s);
    logic [7:0] p[18];
    logic [7:0] c;
    exp_q.push_back({2'b00, s});
    blk.push_back(s);
    if (blk.size() == 16) begin
      for (int i = 0; i < 16; i++) p[i] = blk[i];
      p[16] = 8'h00;
      p[17] = 8'h00;
      for (int i = 0; i < 16; i++) begin
        c = p[i];
        p[i+1] = p[i+1] ^ fmul(c, 8'h06);
        p[i+2] = p[i+2] ^ fmul(c, 8'h08);
      end
      exp_q.push_back({2'b01, p[16]});
      exp_q.push_back({2'b11, p[17]});
      blk.delete();
    end
  endtask

  task automatic step(input logic v, input logic [7:0] s, input logic r,
                      output logic ir, output logic ov, output logic acc);
    logic [9:0] got;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_symbol = s;
    bus.out_ready = r;
    #1;
    ir  = bus.in_ready;
    ov  = bus.out_valid;
    got = {bus.out_last, bus.out_parity, bus.out_symbol};
    if (stall_prev) chk("stall_stable", 32'({ov, got}), 32'({1'b1, stall_val}));
    if (ov && r) begin
      chk("pop_expected", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() != 0) chk("stream", 32'(got), 32'(exp_q.pop_front()));
      rx.push_back(got[7:0]);
      npop++;
      if (got[8] && !got[9]) seen_p1 = got[7:0];
      if (got[9]) begin
        seen_p0 = got[7:0];
        chk("block_len", 32'(rx.size()), 32'd18);
        chk("syn_alpha", 32'(eval_at(8'h02)), 32'd0);
        chk("syn_alpha2", 32'(eval_at(8'h04)), 32'd0);
        nblk++;
        rx.delete();
      end
    end
    stall_prev = ov && !r;
    stall_val  = got;
    acc = v && ir;
    if (acc) push_model(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    blk.delete();
    rx.delete();
    stall_prev = 1'b0;
    npop = 0;
    nblk = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_symbol", 32'(bus.out_symbol), 32'd0);
    chk("rst_out_parity", 32'(bus.out_parity), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send_block(input logic [7:0] d[16], input int pv, input int pr);
    int   i;
    int   guard;
    logic ir, ov, a;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 2000) begin
      step($urandom_range(99) < pv, d[i], $urandom_range(99) < pr, ir, ov, a);
      if (a) i++;
      guard++;
    end
    chk("send_timeout", 32'(i), 32'd16);
  endtask

  task automatic drain(input int pr);
    int   guard;
    logic ir, ov, a;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      step(1'b0, 8'h00, $urandom_range(99) < pr, ir, ov, a);
      guard++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d[16];
    logic       ir, ov, a;
    int         nacc;

    exp_t[0] = 8'h01;
    log_t[0] = 0;
    log_t[1] = 0;
    for (int i = 1; i < 255; i++) begin
      exp_t[i] = {exp_t[i-1][6:0], 1'b0} ^ (exp_t[i-1][7] ? 8'h1D : 8'h00);
      log_t[exp_t[i]] = i;
    end
    bus.in_valid  = 1'b0;
    bus.in_symbol = 8'h00;
    bus.out_ready = 1'b0;

    // All-zero block
    do_reset();
    foreach (d[i]) d[i] = 8'h00;
    send_block(d, 100, 100);
    drain(100);
    chk("zero_p1", 32'(seen_p1), 32'h00);
    chk("zero_p0", 32'(seen_p0), 32'h00);
    chk("zero_nblk", 32'(nblk), 32'd1);

    // Impulse at d15
    d[15] = 8'h01;
    send_block(d, 100, 100);
    drain(100);
    chk("imp15_p1", 32'(seen_p1), 32'h06);
    chk("imp15_p0", 32'(seen_p0), 32'h08);

    // Impulse at d14
    d[15] = 8'h00;
    d[14] = 8'h01;
    send_block(d, 100, 100);
    drain(100);
    chk("imp14_p1", 32'(seen_p1), 32'h1C);
    chk("imp14_p0", 32'(seen_p0), 32'h30);

    // Reset after 7 accepted symbols, then a clean impulse block
    nacc = 0;
    for (int k = 0; k < 40 && nacc < 7; k++) begin
      step(1'b1, 8'($urandom), 1'b1, ir, ov, a);
      if (a) nacc++;
    end
    chk("partial_accepted", 32'(nacc), 32'd7);
    do_reset();
    foreach (d[i]) d[i] = 8'h00;
    d[15] = 8'h01;
    send_block(d, 100, 100);
    drain(100);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, ir, ov, a);
    chk("rst_mid_p1", 32'(seen_p1), 32'h06);
    chk("rst_mid_p0", 32'(seen_p0), 32'h08);
    chk("rst_mid_npop", 32'(npop), 32'd18);
    chk("rst_mid_nblk", 32'(nblk), 32'd1);

    // Continuous streaming, 4 blocks
    do_reset();
    nacc = 0;
    for (int k = 0; k < 73; k++) begin
      step(nacc < 64, 8'($urandom), 1'b1, ir, ov, a);
      if (a) nacc++;
      if (k < 72) chk("cont_in_ready", 32'(ir), 32'((k % 18) < 16));
      if (k >= 1) chk("cont_out_valid", 32'(ov), 32'd1);
    end
    drain(100);
    chk("cont_nblk", 32'(nblk), 32'd4);
    chk("cont_npop", 32'(npop), 32'd72);

    // Random blocks under backpressure and input gaps
    do_reset();
    for (int b = 0; b < 100; b++) begin
      foreach (d[i]) d[i] = 8'($urandom);
      send_block(d, 70, 50);
    end
    drain(50);
    chk("rand_nblk", 32'(nblk), 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
